// File: rtl/lap_apb_pkg.sv
// Shared types and constants for the stopwatch lap-to-APB writer.
package lap_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam logic [3:0]  APB_STRB_ALL  = 4'b1111;
    localparam logic [15:0] DEF_BASE_ADDR = 16'h1000;

    // Registered APB request driven onto the bus.
    typedef struct packed {
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [3:0]  pstrb;
        logic [15:0] paddr;
        logic [31:0] pwdata;
    } apb_req_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic apb_req_t apb_setup(input logic [15:0] addr, input logic [31:0] data);
        apb_req_t req;
        req.psel    = 1'b1;
        req.penable = 1'b0;
        req.pwrite  = 1'b1;
        req.pstrb   = APB_STRB_ALL;
        req.paddr   = addr;
        req.pwdata  = data;
        return req;
    endfunction

endpackage

// File: rtl/lap_apb_writer_if.sv
// APB write bus between the lap writer (master) and the SRAM slave.
interface lap_apb_writer_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, pstrb, paddr, pwdata,
        input  pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, pstrb, paddr, pwdata,
        output pready, pslverr
    );
endinterface

// File: rtl/lap_fifo.sv
// Synchronous capture FIFO; exposes the head and the entry behind it so a
// back-to-back transfer can load its data in the same cycle as the pop.
module lap_fifo
    import lap_apb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [WIDTH-1:0]       dout_next,
    output logic [clog2(DEPTH):0]  count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d, rd_nxt_s;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push_s, do_pop_s;

    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == {CW{1'b0}});
    assign count     = cnt_q;
    assign rd_nxt_s  = rd_q + AW'(1);
    assign dout      = mem_q[rd_q];
    assign dout_next = mem_q[rd_nxt_s];

    // Next-state pointers, count and storage.
    always_comb begin
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        do_push_s = push & ~full & ~flush;
        do_pop_s  = pop & ~empty & ~flush;
        if (flush) begin
            wr_d  = {AW{1'b0}};
            rd_d  = {AW{1'b0}};
            cnt_d = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + AW'(1);
            end else begin
                wr_d = wr_q;
            end
            if (do_pop_s) begin
                rd_d = rd_nxt_s;
            end else begin
                rd_d = rd_q;
            end
            cnt_d = cnt_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= {AW{1'b0}};
            rd_q  <= {AW{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lap_apb_writer.sv
// Captures stopwatch laps into a FIFO and writes them as APB transfers into a
// ring of word slots; reports count, overflow and slave-error status.
module lap_apb_writer
    import lap_apb_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          NUM_SLOTS  = 16,
    parameter int          FIFO_DEPTH = 4,
    localparam int         PTR_W      = clog2(NUM_SLOTS),
    localparam int         FCW        = clog2(FIFO_DEPTH) + 1
) (
    input  logic               iPCLK,
    input  logic               iRST,
    input  logic               iLAP_STORE,
    input  logic [31:0]        iLAP_DATA,
    input  logic               iCLEAR,
    lap_apb_writer_if.master   apb,
    output logic [PTR_W-1:0]   oWR_PTR,
    output logic [PTR_W:0]     oLAP_COUNT,
    output logic               oOVF,
    output logic               oERR,
    output logic               oBUSY
);
    apb_state_e       state_q, state_d;
    apb_req_t         req_q, req_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   lap_cnt_q, lap_cnt_d;
    logic             ovf_q, ovf_d, err_q, err_d;
    logic             clr_pend_q, clr_pend_d, busy_q, busy_d;

    logic             push_s, pop_s, flush_s, clr_now_s;
    logic [31:0]      fifo_dout_s, fifo_dout_next_s;
    logic [FCW-1:0]   fifo_cnt_s, fifo_cnt_nxt_s;
    logic             fifo_full_s, fifo_empty_s;

    function automatic logic [15:0] slot_addr(input logic [PTR_W-1:0] ptr);
        return BASE_ADDR + 16'({ptr, 2'b00});
    endfunction

    lap_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (iPCLK),
        .rst       (iRST),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (flush_s),
        .din       (iLAP_DATA),
        .dout      (fifo_dout_s),
        .dout_next (fifo_dout_next_s),
        .count     (fifo_cnt_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // FSM next state, APB request and status updates.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        wr_ptr_d   = wr_ptr_q;
        lap_cnt_d  = lap_cnt_q;
        err_d      = err_q;
        clr_pend_d = clr_pend_q;
        flush_s    = 1'b0;
        pop_s      = 1'b0;
        push_s     = iLAP_STORE & ~fifo_full_s;
        ovf_d      = ovf_q | (iLAP_STORE & fifo_full_s);
        clr_now_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iCLEAR) begin
                    clr_now_s = 1'b1;
                end else if (!fifo_empty_s) begin
                    state_d = ST_SETUP;
                    req_d   = apb_setup(slot_addr(wr_ptr_q), fifo_dout_s);
                end else begin
                    req_d = '0;
                end
            end
            ST_SETUP: begin
                state_d       = ST_ACCESS;
                req_d.penable = 1'b1;
                clr_pend_d    = clr_pend_q | iCLEAR;
            end
            ST_ACCESS: begin
                clr_pend_d = clr_pend_q | iCLEAR;
                if (!apb.pready) begin
                    state_d = ST_ACCESS;
                end else if (clr_pend_q || iCLEAR) begin
                    // A clear raised mid-transfer discards this completion.
                    clr_now_s  = 1'b1;
                    clr_pend_d = 1'b0;
                    state_d    = ST_IDLE;
                    req_d      = '0;
                end else begin
                    pop_s    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (lap_cnt_q != (PTR_W + 1)'(NUM_SLOTS)) begin
                        lap_cnt_d = lap_cnt_q + (PTR_W + 1)'(1);
                    end else begin
                        lap_cnt_d = lap_cnt_q;
                    end
                    if (apb.pslverr) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    // Next head is the second entry, or the lap pushed this edge.
                    if ((fifo_cnt_s > FCW'(1)) || push_s) begin
                        state_d = ST_SETUP;
                        req_d   = apb_setup(slot_addr(wr_ptr_d),
                                            (fifo_cnt_s > FCW'(1)) ? fifo_dout_next_s : iLAP_DATA);
                    end else begin
                        state_d = ST_IDLE;
                        req_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = '0;
            end
        endcase

        if (clr_now_s) begin
            wr_ptr_d  = {PTR_W{1'b0}};
            lap_cnt_d = {(PTR_W + 1){1'b0}};
            ovf_d     = 1'b0;
            err_d     = 1'b0;
            flush_s   = 1'b1;
            push_s    = 1'b0;
            pop_s     = 1'b0;
        end else begin
            flush_s = 1'b0;
        end

        if (flush_s) begin
            fifo_cnt_nxt_s = {FCW{1'b0}};
        end else begin
            fifo_cnt_nxt_s = fifo_cnt_s + FCW'(push_s) - FCW'(pop_s);
        end
        busy_d = (state_d != ST_IDLE) | (fifo_cnt_nxt_s != {FCW{1'b0}});
    end

    // State and output registers.
    always_ff @(posedge iPCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            wr_ptr_q   <= {PTR_W{1'b0}};
            lap_cnt_q  <= {(PTR_W + 1){1'b0}};
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            wr_ptr_q   <= wr_ptr_d;
            lap_cnt_q  <= lap_cnt_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            clr_pend_q <= clr_pend_d;
            busy_q     <= busy_d;
        end
    end

    assign apb.psel    = req_q.psel;
    assign apb.penable = req_q.penable;
    assign apb.pwrite  = req_q.pwrite;
    assign apb.pstrb   = req_q.pstrb;
    assign apb.paddr   = req_q.paddr;
    assign apb.pwdata  = req_q.pwdata;
    assign oWR_PTR     = wr_ptr_q;
    assign oLAP_COUNT  = lap_cnt_q;
    assign oOVF        = ovf_q;
    assign oERR        = err_q;
    assign oBUSY       = busy_q;

endmodule

// File: tb/tb_lap_apb_writer.sv
// Directed self-checking bench for lap_apb_writer (BASE 16'h1000, 16 slots, FIFO 4).
module tb_lap_apb_writer;

    logic        clk = 1'b0;
    logic        rst, lap_store, clr;
    logic [31:0] lap_data;
    logic [3:0]  wr_ptr;
    logic [4:0]  lap_count;
    logic        ovf, err, busy;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [15:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [3:0]  wr_strb_q [$];
    logic        wr_we_q   [$];

    always #5 clk = ~clk;

    lap_apb_writer_if apb_if ();

    lap_apb_writer #(
        .BASE_ADDR  (16'h1000),
        .NUM_SLOTS  (16),
        .FIFO_DEPTH (4)
    ) dut (
        .iPCLK      (clk),
        .iRST       (rst),
        .iLAP_STORE (lap_store),
        .iLAP_DATA  (lap_data),
        .iCLEAR     (clr),
        .apb        (apb_if),
        .oWR_PTR    (wr_ptr),
        .oLAP_COUNT (lap_count),
        .oOVF       (ovf),
        .oERR       (err),
        .oBUSY      (busy)
    );

    wire [66:0] all_out = {apb_if.psel, apb_if.penable, apb_if.pwrite, apb_if.pstrb, apb_if.paddr,
                           apb_if.pwdata, wr_ptr, lap_count, ovf, err, busy};

    // Log every APB completion seen on the bus (inputs only change just after posedge).
    always @(negedge clk) begin
        if (rst === 1'b0 && apb_if.psel === 1'b1 && apb_if.penable === 1'b1 && apb_if.pready === 1'b1) begin
            wr_addr_q.push_back(apb_if.paddr);
            wr_data_q.push_back(apb_if.pwdata);
            wr_strb_q.push_back(apb_if.pstrb);
            wr_we_q.push_back(apb_if.pwrite);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lap(input logic [31:0] d);
        lap_store = 1'b1;
        lap_data  = d;
        tick(1);
        lap_store = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; lap_store = 1'b0; lap_data = 32'h0; clr = 1'b0;
        apb_if.pready = 1'b1; apb_if.pslverr = 1'b0;
        tick(3);
        n_checks++; if (all_out !== 67'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        rst = 1'b0;
        tick(2);
        n_checks++; if (all_out !== 67'd0) begin n_fail++; $display("FAIL post_reset_idle: got %h expected 0", all_out); end
    endtask

    task automatic test_single();
        wr_addr_q.delete(); wr_data_q.delete(); wr_strb_q.delete(); wr_we_q.delete();
        lap(32'h0000_1234);
        n_checks++; if ({busy, apb_if.psel} !== 2'b10) begin n_fail++; $display("FAIL single_capture: busy,psel got %b expected 10", {busy, apb_if.psel}); end
        tick(1);
        n_checks++; if ({apb_if.psel, apb_if.penable, apb_if.pwrite, apb_if.pstrb} !== 7'b101_1111) begin n_fail++; $display("FAIL single_setup_ctl: got %b expected 1011111", {apb_if.psel, apb_if.penable, apb_if.pwrite, apb_if.pstrb}); end
        n_checks++; if ({apb_if.paddr, apb_if.pwdata} !== {16'h1000, 32'h0000_1234}) begin n_fail++; $display("FAIL single_setup_addr_data: got %h %h expected 1000 00001234", apb_if.paddr, apb_if.pwdata); end
        tick(1);
        n_checks++; if ({apb_if.psel, apb_if.penable} !== 2'b11) begin n_fail++; $display("FAIL single_access: got %b expected 11", {apb_if.psel, apb_if.penable}); end
        tick(1);
        n_checks++; if ({apb_if.psel, apb_if.penable, busy, wr_ptr, lap_count} !== {3'b000, 4'd1, 5'd1}) begin n_fail++; $display("FAIL single_done: psel,pen,busy,ptr,cnt got %b expected 000_0001_00001", {apb_if.psel, apb_if.penable, busy, wr_ptr, lap_count}); end
        n_checks++; if (wr_addr_q.size() !== 1 || wr_strb_q[0] !== 4'hF || wr_we_q[0] !== 1'b1 || wr_data_q[0] !== 32'h0000_1234)
            begin n_fail++; $display("FAIL single_bus_write: writes got %0d expected 1 with strb F data 00001234", wr_addr_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ea [3];
        logic [31:0] ed [3];
        logic        psel_all;
        ea = '{16'h1000, 16'h1004, 16'h1008};
        ed = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        do_clear();
        n_checks++; if ({wr_ptr, lap_count} !== 9'd0) begin n_fail++; $display("FAIL b2b_clear: got %h expected 0", {wr_ptr, lap_count}); end
        wr_addr_q.delete(); wr_data_q.delete();
        psel_all = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lap(ed[i]);
            lap_store = (i < 2) ? 1'b1 : 1'b0;
            if (i > 0) psel_all = psel_all & apb_if.psel;
        end
        lap_store = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            psel_all = psel_all & apb_if.psel;
        end
        n_checks++; if (psel_all !== 1'b1) begin n_fail++; $display("FAIL b2b_no_idle_gap: psel dropped, got %b expected 1", psel_all); end
        tick(1);
        n_checks++; if ({apb_if.psel, busy, lap_count, wr_ptr} !== {2'b00, 5'd3, 4'd3}) begin n_fail++; $display("FAIL b2b_done: got %b expected 00_00011_0011", {apb_if.psel, busy, lap_count, wr_ptr}); end
        n_checks++; if (wr_addr_q.size() !== 3) begin n_fail++; $display("FAIL b2b_write_count: got %0d expected 3", wr_addr_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if ({wr_addr_q[i], wr_data_q[i]} !== {ea[i], ed[i]}) begin n_fail++; $display("FAIL b2b_write%0d: got %h %h expected %h %h", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]); end
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        do_clear();
        wr_addr_q.delete(); wr_data_q.delete();
        apb_if.pready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            lap_store = 1'b1;
            lap_data  = 32'h0000_0100 + 32'(i);
            tick(1);
        end
        lap_store = 1'b0;
        n_checks++; if ({ovf, apb_if.psel, apb_if.penable} !== 3'b111) begin n_fail++; $display("FAIL ovf_set_and_wait: ovf,psel,pen got %b expected 111", {ovf, apb_if.psel, apb_if.penable}); end
        apb_if.pready = 1'b1;
        wait_idle(50, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_timeout: busy still %b expected 0", busy); end
        n_checks++; if (wr_addr_q.size() !== 4) begin n_fail++; $display("FAIL ovf_write_count: got %0d expected 4", wr_addr_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if ({wr_addr_q[i], wr_data_q[i]} !== {16'h1000 + 16'(4 * i), 32'h0000_0100 + 32'(i)}) begin n_fail++; $display("FAIL ovf_write%0d: got %h %h", i, wr_addr_q[i], wr_data_q[i]); end
            end
        end
        n_checks++; if ({ovf, lap_count, wr_ptr} !== {1'b1, 5'd4, 4'd4}) begin n_fail++; $display("FAIL ovf_status: got %b expected 1_00100_0100", {ovf, lap_count, wr_ptr}); end
    endtask

    task automatic test_wrap();
        bit ok;
        int timeouts;
        timeouts = 0;
        do_clear();
        wr_addr_q.delete(); wr_data_q.delete();
        for (int i = 0; i < 17; i++) begin
            lap(32'h5A00_0000 + 32'(i));
            wait_idle(20, ok);
            if (!ok) timeouts++;
            if (i == 15) begin
                n_checks++; if ({wr_ptr, lap_count} !== {4'd0, 5'd16}) begin n_fail++; $display("FAIL wrap_16th: ptr,cnt got %h %h expected 0 10", wr_ptr, lap_count); end
            end
        end
        n_checks++; if (timeouts !== 0) begin n_fail++; $display("FAIL wrap_timeouts: got %0d expected 0", timeouts); end
        n_checks++; if (wr_addr_q.size() !== 17) begin n_fail++; $display("FAIL wrap_write_count: got %0d expected 17", wr_addr_q.size()); end
        else begin
            n_checks++; if (wr_addr_q[15] !== 16'h103C) begin n_fail++; $display("FAIL wrap_last_slot: got %h expected 103c", wr_addr_q[15]); end
            n_checks++; if ({wr_addr_q[16], wr_data_q[16]} !== {16'h1000, 32'h5A00_0010}) begin n_fail++; $display("FAIL wrap_17th: got %h %h expected 1000 5a000010", wr_addr_q[16], wr_data_q[16]); end
        end
        n_checks++; if ({wr_ptr, lap_count} !== {4'd1, 5'd16}) begin n_fail++; $display("FAIL wrap_saturate: ptr,cnt got %h %h expected 1 10", wr_ptr, lap_count); end
    endtask

    task automatic test_slverr_clear();
        bit ok;
        int sz;
        do_clear();
        wr_addr_q.delete(); wr_data_q.delete();
        lap(32'h0E00_0001);
        wait_idle(20, ok);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clean: got %b expected 0", err); end
        apb_if.pslverr = 1'b1;
        lap(32'h0E00_0002);
        wait_idle(20, ok);
        apb_if.pslverr = 1'b0;
        n_checks++; if ({err, wr_ptr, lap_count, 8'(wr_addr_q.size())} !== {1'b1, 4'd2, 5'd2, 8'd2}) begin n_fail++; $display("FAIL err_set: err,ptr,cnt got %b %h %h expected 1 2 2", err, wr_ptr, lap_count); end
        lap(32'h0E00_0003);
        wait_idle(20, ok);
        n_checks++; if ({err, wr_ptr} !== {1'b1, 4'd3}) begin n_fail++; $display("FAIL err_sticky: err,ptr got %b %h expected 1 3", err, wr_ptr); end
        apb_if.pready = 1'b0;
        for (int i = 0; i < 5; i++) lap(32'h0F00_0000 + 32'(i));
        apb_if.pready = 1'b1;
        wait_idle(50, ok);
        n_checks++; if ({ok, ovf, err} !== 3'b111) begin n_fail++; $display("FAIL err_ovf_before_clear: ok,ovf,err got %b expected 111", {ok, ovf, err}); end
        clr = 1'b1; lap_store = 1'b1; lap_data = 32'hDEAD_BEEF;
        tick(1);
        clr = 1'b0; lap_store = 1'b0;
        n_checks++; if ({err, ovf, wr_ptr, lap_count, busy} !== 12'd0) begin n_fail++; $display("FAIL idle_clear: err,ovf,ptr,cnt,busy got %b expected 0", {err, ovf, wr_ptr, lap_count, busy}); end
        sz = wr_addr_q.size();
        tick(4);
        n_checks++; if (wr_addr_q.size() !== sz) begin n_fail++; $display("FAIL clear_drops_store: writes got %0d expected %0d", wr_addr_q.size(), sz); end
    endtask

    task automatic test_clear_pending();
        bit ok;
        logic held;
        wr_addr_q.delete(); wr_data_q.delete();
        lap(32'hC100_0001);
        wait_idle(20, ok);
        apb_if.pready = 1'b0;
        lap(32'hC100_0002);
        lap(32'hC100_0003);
        tick(1);
        n_checks++; if ({apb_if.psel, apb_if.penable, apb_if.paddr} !== {2'b11, 16'h1004}) begin n_fail++; $display("FAIL pend_in_access: got %b %h expected 11 1004", {apb_if.psel, apb_if.penable}, apb_if.paddr); end
        held = 1'b1;
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            held = held & apb_if.psel & apb_if.penable & (apb_if.paddr == 16'h1004);
        end
        clr = 1'b0;
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL pend_not_aborted: got %b expected 1", held); end
        apb_if.pready = 1'b1;
        tick(1);
        n_checks++; if ({apb_if.psel, busy, wr_ptr, lap_count} !== 11'd0) begin n_fail++; $display("FAIL pend_applied: psel,busy,ptr,cnt got %b expected 0", {apb_if.psel, busy, wr_ptr, lap_count}); end
        tick(4);
        n_checks++; if (wr_addr_q.size() !== 2) begin n_fail++; $display("FAIL pend_write_count: got %0d expected 2", wr_addr_q.size()); end
        else begin
            n_checks++; if ({wr_addr_q[1], wr_data_q[1]} !== {16'h1004, 32'hC100_0002}) begin n_fail++; $display("FAIL pend_write: got %h %h expected 1004 c1000002", wr_addr_q[1], wr_data_q[1]); end
        end
    endtask

    task automatic test_async_reset();
        int sz;
        sz = wr_addr_q.size();
        apb_if.pready = 1'b0;
        lap(32'hAB00_0001);
        tick(2);
        n_checks++; if ({apb_if.psel, apb_if.penable} !== 2'b11) begin n_fail++; $display("FAIL rst_pre_access: got %b expected 11", {apb_if.psel, apb_if.penable}); end
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (all_out !== 67'd0) begin n_fail++; $display("FAIL rst_async_drop: got %h expected 0", all_out); end
        tick(2);
        rst = 1'b0;
        apb_if.pready = 1'b1;
        tick(3);
        n_checks++; if (all_out !== 67'd0 || wr_addr_q.size() !== sz) begin n_fail++; $display("FAIL rst_no_completion: outputs %h writes %0d expected 0 and %0d", all_out, wr_addr_q.size(), sz); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_slverr_clear();
        test_clear_pending();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
